uart_tx: RTL and testbench

- UART 8N1 transmitter: the return path of the host link. The receive side takes print data in on Rx; this block sends status/acknowledge bytes back to the host on Tx.
- Sits beside the RX receiver in the top level and shares the same CLK.
- Bytes come from control logic through a small write-only FIFO, so a burst of status bytes never stalls the printer datapath.

---
 rtl/uart_tx.sv | 158 +++++++++++++++
 tb/tb_uart_tx.sv | 233 +++++++++++++++++++++++
 2 files changed

// File: rtl/uart_tx.sv
// UART 8N1 transmitter for the host return link: a small write-only byte FIFO
// feeding a start/data/stop serialiser with a registered, glitch-free Tx line.
//
// state   | meaning
// --------+----------------------------------------------------------
// S_IDLE  | line high, waiting for a queued byte
// S_START | start bit (Tx=0) for one bit period
// S_DATA  | eight data bits, LSB first, one bit period each
// S_STOP  | stop bit (Tx=1); chains straight into S_START if more queued
module uart_tx #(
    parameter int CLK_FREQ   = 50000000,
    parameter int BAUD       = 9600,
    parameter int FIFO_DEPTH = 4
) (
    input  logic       CLK,
    input  logic       RST,
    input  logic [7:0] DATA,
    input  logic       WR,
    output logic       FULL,
    output logic       BUSY,
    output logic       OVF,
    output logic       Tx
);

    localparam int BAUD_DIV = CLK_FREQ / BAUD;
    localparam int CW       = (BAUD_DIV > 1) ? $clog2(BAUD_DIV) : 1;
    localparam int PW       = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam logic [CW-1:0] BAUD_LAST = CW'(BAUD_DIV - 1);
    localparam logic [PW:0]   CNT_FULL  = (PW + 1)'(FIFO_DEPTH);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_START = 2'd1,
        S_DATA  = 2'd2,
        S_STOP  = 2'd3
    } state_t;

    state_t        state, state_d;
    logic [CW-1:0] baud_cnt, baud_d;
    logic [2:0]    bit_idx, bit_d;
    logic [7:0]    shift, shift_d;
    logic          tx_d;

    logic [7:0]    mem [FIFO_DEPTH];
    logic [PW-1:0] wr_ptr, rd_ptr;
    logic [PW:0]   count;
    logic          wr_en, pop, empty, last;

    assign empty = (count == '0);
    assign FULL  = (count == CNT_FULL);
    assign BUSY  = (state != S_IDLE) || !empty;
    // FULL is the pre-edge value, so a same-edge pop never makes room for a write
    assign wr_en = WR && !FULL;
    assign last  = (baud_cnt == BAUD_LAST);

    always_ff @(posedge CLK) begin
        if (wr_en) begin
            mem[wr_ptr] <= DATA;
        end
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            OVF    <= 1'b0;
        end else begin
            if (wr_en) wr_ptr <= wr_ptr + PW'(1);
            if (pop)   rd_ptr <= rd_ptr + PW'(1);
            case ({wr_en, pop})
                2'b10:   count <= count + (PW + 1)'(1);
                2'b01:   count <= count - (PW + 1)'(1);
                default: count <= count;
            endcase
            if (WR && FULL) OVF <= 1'b1;
        end
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state    <= S_IDLE;
            baud_cnt <= '0;
            bit_idx  <= '0;
            shift    <= '0;
            Tx       <= 1'b1;
        end else begin
            state    <= state_d;
            baud_cnt <= baud_d;
            bit_idx  <= bit_d;
            shift    <= shift_d;
            Tx       <= tx_d;
        end
    end

    always_comb begin
        state_d = state;
        baud_d  = baud_cnt + CW'(1);
        bit_d   = bit_idx;
        shift_d = shift;
        pop     = 1'b0;
        case (state)
            S_IDLE: begin
                baud_d = '0;
                if (!empty) begin
                    pop     = 1'b1;
                    shift_d = mem[rd_ptr];
                    state_d = S_START;
                end
            end
            S_START: begin
                if (last) begin
                    baud_d  = '0;
                    bit_d   = '0;
                    state_d = S_DATA;
                end
            end
            S_DATA: begin
                if (last) begin
                    baud_d = '0;
                    if (bit_idx == 3'd7) begin
                        state_d = S_STOP;
                    end else begin
                        shift_d = shift >> 1;
                        bit_d   = bit_idx + 3'd1;
                    end
                end
            end
            S_STOP: begin
                if (last) begin
                    baud_d = '0;
                    if (!empty) begin
                        pop     = 1'b1;
                        shift_d = mem[rd_ptr];
                        state_d = S_START;
                    end else begin
                        state_d = S_IDLE;
                    end
                end
            end
            default: begin
                state_d = S_IDLE;
                baud_d  = '0;
            end
        endcase
    end

    // Tx is computed from the next state so the line changes on the same edge as the FSM
    always_comb begin
        tx_d = 1'b1;
        case (state_d)
            S_START: tx_d = 1'b0;
            S_DATA:  tx_d = shift_d[0];
            default: tx_d = 1'b1;
        endcase
    end

endmodule

// File: tb/tb_uart_tx.sv
// Bench for uart_tx with BAUD_DIV=16: table of single frames plus hand-written
// back-to-back, overflow, write-while-pop and mid-frame reset sequences.
module tb_uart_tx;

    localparam int BD    = 16;
    localparam int FRAME = 10 * BD;
    localparam int LOGN  = 8192;

    logic       clk  = 1'b0;
    logic       rst  = 1'b1;
    logic       wr   = 1'b0;
    logic [7:0] data = 8'h00;
    logic       full, busy, ovf, tx;

    always #5 clk = ~clk;

    uart_tx #(.CLK_FREQ(16), .BAUD(1), .FIFO_DEPTH(4)) dut (
        .CLK(clk), .RST(rst), .DATA(data), .WR(wr),
        .FULL(full), .BUSY(busy), .OVF(ovf), .Tx(tx)
    );

    typedef struct {
        logic [7:0] data;
        logic [9:0] line;   // line[0] = start bit ... line[9] = stop bit
    } vec_t;

    vec_t       vecs [6];
    int         n_vec = 0;
    int         n_err = 0;
    int         cyc   = 0;
    logic       tx_log   [LOGN];
    logic       busy_log [LOGN];
    logic [9:0] exp_frames [8];

    // recorder: sample k is taken 1 ns after rising edge k
    initial begin
        forever begin
            @(posedge clk);
            #1;
            cyc = cyc + 1;
            if (cyc < LOGN) begin
                tx_log[cyc]   = tx;
                busy_log[cyc] = busy;
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, got timeout, expected finish");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic write_byte(input logic [7:0] b);
        data = b;
        wr   = 1'b1;
        tick();
        wr   = 1'b0;
        data = ~b;
    endtask

    task automatic wait_until(input int c);
        while (cyc < c) tick();
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        tick();
    endtask

    // t0 = sample index of the edge that wrote the first byte
    task automatic check_stream(input string name, input int t0, input int n);
        logic ok;
        int   idx;
        wait_until(t0 + FRAME * n + 2);
        check($sformatf("%s pre_start_tx", name), tx_log[t0], 1);
        for (int k = 0; k < n; k++) begin
            for (int i = 0; i < 10; i++) begin
                ok = 1'b1;
                for (int j = 0; j < BD; j++) begin
                    idx = t0 + 1 + FRAME * k + BD * i + j;
                    if (tx_log[idx] !== exp_frames[k][i]) ok = 1'b0;
                end
                check($sformatf("%s frame%0d bit%0d", name, k, i), ok, 1);
            end
        end
        ok = 1'b1;
        for (int s = t0; s <= t0 + FRAME * n; s++) begin
            if (busy_log[s] !== 1'b1) ok = 1'b0;
        end
        check($sformatf("%s busy_span", name), ok, 1);
        check($sformatf("%s busy_end", name), busy_log[t0 + FRAME * n + 1], 0);
        check($sformatf("%s tx_end", name), tx_log[t0 + FRAME * n + 1], 1);
    endtask

    initial begin
        int   t0;
        logic ok;

        vecs[0] = '{8'hA5, 10'b1_10100101_0};
        vecs[1] = '{8'h00, 10'b1_00000000_0};
        vecs[2] = '{8'hFF, 10'b1_11111111_0};
        vecs[3] = '{8'h3C, 10'b1_00111100_0};
        vecs[4] = '{8'h81, 10'b1_10000001_0};
        vecs[5] = '{8'h6B, 10'b1_01101011_0};

        repeat (3) tick();
        rst = 1'b0;
        tick();
        check("reset tx", tx, 1);
        check("reset busy", busy, 0);
        check("reset full", full, 0);
        check("reset ovf", ovf, 0);

        ok = 1'b1;
        repeat (1000) begin
            tick();
            if (tx !== 1'b1 || busy !== 1'b0) ok = 1'b0;
        end
        check("idle line", ok, 1);

        for (int v = 0; v < 6; v++) begin
            write_byte(vecs[v].data);
            t0 = cyc;
            exp_frames[0] = vecs[v].line;
            check_stream($sformatf("vec%0d", v), t0, 1);
            tick();
        end

        // back-to-back: 2*160+1 busy samples, no idle gap between frames
        write_byte(8'h00);
        t0 = cyc;
        write_byte(8'hFF);
        exp_frames[0] = {1'b1, 8'h00, 1'b0};
        exp_frames[1] = {1'b1, 8'hFF, 1'b0};
        check_stream("b2b", t0, 2);
        tick();

        // full / overflow with first frame already started
        write_byte(8'h11);
        t0 = cyc;
        tick();
        write_byte(8'h01);
        write_byte(8'h02);
        write_byte(8'h03);
        check("ovf full_after_3", full, 0);
        write_byte(8'h04);
        check("ovf full_after_4", full, 1);
        check("ovf ovf_before_drop", ovf, 0);
        write_byte(8'h05);
        check("ovf full_after_5", full, 1);
        check("ovf ovf_set", ovf, 1);
        exp_frames[0] = {1'b1, 8'h11, 1'b0};
        exp_frames[1] = {1'b1, 8'h01, 1'b0};
        exp_frames[2] = {1'b1, 8'h02, 1'b0};
        exp_frames[3] = {1'b1, 8'h03, 1'b0};
        exp_frames[4] = {1'b1, 8'h04, 1'b0};
        check_stream("ovf", t0, 5);
        check("ovf sticky", ovf, 1);
        do_reset();
        check("ovf cleared_by_reset", ovf, 0);

        // write on the pop edge at the end of a stop bit keeps the count unchanged
        write_byte(8'hC3);
        t0 = cyc;
        write_byte(8'h18);
        wait_until(t0 + FRAME);
        write_byte(8'h7E);
        check("wwp pop_edge_write_cycle", cyc, t0 + FRAME + 1);
        check("wwp full_after_pop_write", full, 0);
        write_byte(8'hE7);
        write_byte(8'h24);
        check("wwp full_at_3", full, 0);
        write_byte(8'h99);
        check("wwp full_at_4", full, 1);
        check("wwp no_ovf", ovf, 0);
        exp_frames[0] = {1'b1, 8'hC3, 1'b0};
        exp_frames[1] = {1'b1, 8'h18, 1'b0};
        exp_frames[2] = {1'b1, 8'h7E, 1'b0};
        exp_frames[3] = {1'b1, 8'hE7, 1'b0};
        exp_frames[4] = {1'b1, 8'h24, 1'b0};
        exp_frames[5] = {1'b1, 8'h99, 1'b0};
        check_stream("wwp", t0, 6);
        tick();

        // asynchronous reset during data bit 3 with a full FIFO and OVF set
        write_byte(8'h3C);
        t0 = cyc;
        write_byte(8'hA1);
        write_byte(8'hA2);
        write_byte(8'hA3);
        write_byte(8'hA4);
        write_byte(8'hA6);
        check("rst pre full", full, 1);
        check("rst pre ovf", ovf, 1);
        wait_until(t0 + 1 + BD * 4 + 5);
        check("rst pre busy", busy, 1);
        #3;
        rst = 1'b1;
        #1;
        check("rst async tx", tx, 1);
        check("rst async busy", busy, 0);
        check("rst async full", full, 0);
        check("rst async ovf", ovf, 0);
        tick();
        tick();
        rst = 1'b0;
        tick();
        write_byte(8'h55);
        t0 = cyc;
        exp_frames[0] = {1'b1, 8'h55, 1'b0};
        check_stream("post_rst", t0, 1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
